// File: rtl/switch_debounce_pulse.sv
// rtl/switch_debounce_pulse.sv - switch synchronizer, debouncer and rise/auto-repeat/fall pulse generator
module switch_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic level,
    output logic inc_pulse,
    output logic fall_pulse,
    output logic repeat_active
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          sw_meta, sw_sync;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [RW-1:0] rep_cnt, rep_nx;
    logic          differ, accept;
    logic          inc_nx, fall_nx, repeat_nx;

    assign differ = (sw_sync != level);
    assign accept = differ && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (accept) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else if (differ) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // level is 1 exactly while in HOLD/REPEAT, so accept there always means a fall
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        rep_nx   = rep_cnt;
        inc_nx   = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            LOW: begin
                if (accept) begin
                    state_nx = HOLD;
                    inc_nx   = 1'b1;
                    hold_nx  = '0;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nx = LOW;
                    fall_nx  = 1'b1;
                    hold_nx  = '0;
                    rep_nx   = '0;
                end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    if (REPEAT_EN != 0) begin
                        state_nx = REPEAT;
                        inc_nx   = 1'b1;
                        rep_nx   = '0;
                    end
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (accept) begin
                    state_nx = LOW;
                    fall_nx  = 1'b1;
                    hold_nx  = '0;
                    rep_nx   = '0;
                end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                    inc_nx = 1'b1;
                    rep_nx = '0;
                end else begin
                    rep_nx = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = LOW;
                hold_nx  = '0;
                rep_nx   = '0;
            end
        endcase
        repeat_nx = (state_nx == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOW;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            inc_pulse     <= 1'b0;
            fall_pulse    <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state         <= state_nx;
            hold_cnt      <= hold_nx;
            rep_cnt       <= rep_nx;
            inc_pulse     <= inc_nx;
            fall_pulse    <= fall_nx;
            repeat_active <= repeat_nx;
        end
    end

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// tb/tb_switch_debounce_pulse.sv - directed bench with a cycles-since-rise reference model
module tb_switch_debounce_pulse;

    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 3;
    localparam int RE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_in = 1'b0;
    logic level, inc_pulse, fall_pulse, repeat_active;

    switch_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .REPEAT_CYCLES(R),
        .REPEAT_EN(RE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .level(level),
        .inc_pulse(inc_pulse),
        .fall_pulse(fall_pulse),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // model: raw sample pipeline, run length of disagreeing samples, cycles elapsed since rise
    bit m_s1, m_s2, m_lvl, m_inc, m_fall, m_rep;
    int m_run, m_el;
    bit m_inc_at [0:255];
    bit m_fall_at[0:255];
    bit d_inc_at [0:255];
    bit d_fall_at[0:255];

    task automatic step(input logic r, input logic s);
        bit acc;
        rst   = r;
        sw_in = s;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_run = 0; m_lvl = 0; m_el = 0;
            m_inc = 0; m_fall = 0; m_rep = 0;
        end else begin
            acc = 0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == D) begin
                    acc = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = s;
            m_inc = 0;
            m_fall = 0;
            if (acc && !m_lvl) begin
                m_lvl = 1; m_el = 0; m_inc = 1;
            end else if (acc) begin
                m_lvl = 0; m_fall = 1;
            end else if (m_lvl) begin
                m_el++;
                if (RE != 0 && m_el >= H && (m_el - H) % R == 0) m_inc = 1;
            end
            m_rep = m_lvl && (RE != 0) && (m_el >= H);
        end
        m_inc_at[cyc]  = m_inc;
        m_fall_at[cyc] = m_fall;
        d_inc_at[cyc]  = inc_pulse;
        d_fall_at[cyc] = fall_pulse;
        vectors++;
        if ({level, inc_pulse, fall_pulse, repeat_active} !== {m_lvl, m_inc, m_fall, m_rep}) begin
            miscompares++;
            $display("FAIL cycle %0d level/inc/fall/rep: actual %b%b%b%b required %b%b%b%b",
                     cyc, level, inc_pulse, fall_pulse, repeat_active, m_lvl, m_inc, m_fall, m_rep);
        end
    endtask

    task automatic check_bit(input string name, input int c, input bit act, input bit exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, c, act, exp);
        end
    endtask

    task automatic pin(input int c, input bit exp_inc, input bit exp_fall);
        check_bit("model_inc", c, m_inc_at[c], exp_inc);
        check_bit("model_fall", c, m_fall_at[c], exp_fall);
        check_bit("dut_inc", c, d_inc_at[c], exp_inc);
        check_bit("dut_fall", c, d_fall_at[c], exp_fall);
    endtask

    task automatic quiet(input string name, input int lo, input int hi);
        int m_n, d_n;
        m_n = 0;
        d_n = 0;
        for (int i = lo; i <= hi; i++) begin
            m_n += int'(m_inc_at[i]) + int'(m_fall_at[i]);
            d_n += int'(d_inc_at[i]) + int'(d_fall_at[i]);
        end
        vectors++;
        if (m_n != 0) begin
            miscompares++;
            $display("FAIL %s model pulses in %0d..%0d: actual %0d required 0", name, lo, hi, m_n);
        end
        vectors++;
        if (d_n != 0) begin
            miscompares++;
            $display("FAIL %s dut pulses in %0d..%0d: actual %0d required 0", name, lo, hi, d_n);
        end
    endtask

    initial begin
        // reset with switch high, release, hold into auto-repeat, release so fall meets a repeat slot
        repeat (3)  step(1'b1, 1'b1);   // edges 1..3
        repeat (25) step(1'b0, 1'b1);   // edges 4..28
        repeat (12) step(1'b0, 1'b0);   // edges 29..40
        // glitch shorter than the debounce window
        repeat (3)  step(1'b0, 1'b1);   // edges 41..43
        repeat (12) step(1'b0, 1'b0);   // edges 44..55
        // bounce then settle high
        repeat (2)  step(1'b0, 1'b1);   // 56,57
        repeat (2)  step(1'b0, 1'b0);   // 58,59
        repeat (2)  step(1'b0, 1'b1);   // 60,61
        repeat (2)  step(1'b0, 1'b0);   // 62,63
        repeat (19) step(1'b0, 1'b1);   // edges 64..82
        // one-cycle reset mid-repeat with switch still high
        step(1'b1, 1'b1);               // edge 83
        repeat (12) step(1'b0, 1'b1);   // edges 84..95
        repeat (10) step(1'b0, 1'b0);   // edges 96..105

        pin(9, 1, 0);
        pin(18, 0, 0);
        pin(19, 1, 0);
        pin(22, 1, 0);
        pin(25, 1, 0);
        pin(28, 1, 0);
        pin(31, 1, 0);
        pin(34, 0, 1);
        quiet("after_fall_and_glitch", 35, 55);
        quiet("bounce", 56, 68);
        pin(69, 1, 0);
        pin(79, 1, 0);
        pin(82, 1, 0);
        quiet("reset_abort", 83, 88);
        pin(89, 1, 0);
        pin(99, 1, 0);
        pin(101, 0, 1);
        quiet("after_release", 102, 105);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switch_debounce_pulse.md
SWITCH_DEBOUNCE_PULSE -- requirements
Module: switch_debounce_pulse

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples required to accept a level change (>=1).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 25000000: cycles of accepted-high before auto-repeat starts (>=1).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 5000000: cycles between auto-repeat pulses (>=1).
REQ-004 The block SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port sw_in, input, 1 bit: raw asynchronous board switch (SW0).
REQ-008 The block SHALL have port level, output, 1 bit: debounced switch level.
REQ-009 The block SHALL have port inc_pulse, output, 1 bit: one-cycle increment strobe to the downstream 7-segment counter.
REQ-010 The block SHALL have port fall_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-011 The block SHALL have port repeat_active, output, 1 bit: high while in REPEAT state.

Function
REQ-012 sw_in SHALL pass through a 2-flop synchronizer; sw_sync is the second flop.
REQ-013 The debounce counter SHALL increment each cycle that sw_sync != level and SHALL clear to 0 in any cycle that sw_sync == level.
REQ-014 level SHALL toggle at the edge where the DEBOUNCE_CYCLES-th consecutive differing sample occurs; the counter clears on that edge; total latency from a stable sw_in change is DEBOUNCE_CYCLES+2 rising edges.
REQ-015 The counter SHALL be wide enough for DEBOUNCE_CYCLES with no wrap; a differing run shorter than DEBOUNCE_CYCLES SHALL never change level.
REQ-016 The control FSM SHALL have states LOW, HOLD and REPEAT; reset state is LOW.
REQ-017 LOW->HOLD on accepted rise: inc_pulse=1 for exactly one cycle, registered in the same edge that sets level=1; the hold counter clears.
REQ-018 In HOLD, the hold counter increments each cycle; when HOLD_CYCLES cycles have elapsed since the rise pulse and REPEAT_EN=1, the FSM SHALL emit one inc_pulse, enter REPEAT and clear the repeat counter; with REPEAT_EN=0 it SHALL remain in HOLD with no further pulses.
REQ-019 In REPEAT, inc_pulse SHALL assert for one cycle every REPEAT_CYCLES cycles, and repeat_active=1.
REQ-020 On an accepted fall from HOLD or REPEAT, the FSM SHALL go to LOW with fall_pulse=1 for one cycle, registered with level=0; hold and repeat counters clear.
REQ-021 If a scheduled repeat pulse coincides with an accepted fall, fall_pulse SHALL win and inc_pulse SHALL be 0 in that cycle.
REQ-022 Repeat pulses SHALL continue while level is still 1 during a release debounce window; none SHALL occur after level=0.
REQ-023 inc_pulse and fall_pulse SHALL never both be 1, and neither SHALL exceed one cycle per event.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While rst=1 at an edge, the synchronizer flops, all counters, level, inc_pulse, fall_pulse and repeat_active SHALL be 0 and the FSM SHALL be in LOW, regardless of sw_in.
REQ-026 Reset asserted mid-HOLD or mid-REPEAT SHALL abort with no pulse; a switch held high through reset SHALL be re-debounced and produce one fresh rise inc_pulse.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1)
REQ-027 Reset: rst=1 for 3 cycles with sw_in=1, then release -> all outputs 0 during reset; level=1 and inc_pulse=1 for one cycle at the 6th edge after release.
REQ-028 Bounce: sw_in alternates 1,0,1,0 in 2-cycle segments, then holds 1 -> no pulse during bouncing; exactly one inc_pulse 6 edges after the final transition.
REQ-029 Glitch: sw_in=1 for 3 cycles, then 0 -> level stays 0; inc_pulse and fall_pulse stay 0.
REQ-030 Auto-repeat: hold sw_in=1 with rise pulse at cycle t -> inc_pulse at t+10, t+13 and t+16; repeat_active=1 from t+10.
REQ-031 Release: drop sw_in during REPEAT -> fall_pulse 6 edges later; repeat pulses due before then still fire; none after; repeat_active=0 with level=0.
REQ-032 Mid-repeat reset: rst=1 for one cycle at t+14 -> all outputs 0 after the reset edge; the next inc_pulse occurs 6 edges after rst deasserts (sw_in still 1).
